// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - framebuffer geometry, fill op-codes and fill engine state encoding
package screen_pkg;

  localparam int WORDS_PER_ROW = 32;
  localparam int ROWS          = 256;
  localparam int ADDR_W        = 13;

  localparam int X_W = 5;
  localparam int Y_W = 8;

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_XOR   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDW  = 3'd3,
    DONE = 3'd4
  } fill_state_t;

endpackage

// File: rtl/rect_walker.sv
// rtl/rect_walker.sv - row-major x/y walker over a clipped rectangle producing VRAM word addresses
module rect_walker
  import screen_pkg::*;
#(
  parameter int WPR = WORDS_PER_ROW,
  parameter int AW  = ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x_end,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y_end,
  input  logic           load,
  input  logic           step,
  output logic [AW-1:0]  addr,
  output logic           last
);

  logic [X_W-1:0] x, x_start, x_stop;
  logic [Y_W-1:0] y, y_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      x_start <= '0;
      x_stop  <= '0;
      y_stop  <= '0;
    end else if (load) begin
      x       <= x0;
      y       <= y0;
      x_start <= x0;
      x_stop  <= x_end;
      y_stop  <= y_end;
    end else if (step) begin
      // The caller never steps past the last word, so y cannot run beyond y_stop.
      if (x == x_stop) begin
        x <= x_start;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign addr = AW'(y) * AW'(WPR) + AW'(x);
  assign last = (x == x_stop) && (y == y_stop);

endmodule

// File: rtl/vram_fill.sv
// rtl/vram_fill.sv - rectangle FILL/XOR/CLEAR engine driving the VRAM write port under the busy handshake
module vram_fill #(
  parameter int WORDS_PER_ROW = screen_pkg::WORDS_PER_ROW,
  parameter int ROWS          = screen_pkg::ROWS,
  parameter int ADDR_W        = screen_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [4:0]        cmd_x0,
  input  logic [7:0]        cmd_y0,
  input  logic [5:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [15:0]       cmd_pattern,
  output logic              active,
  output logic              done,
  output logic              vram_load,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_din,
  input  logic              vram_busy,
  input  logic [15:0]       vram_dout
);
  import screen_pkg::*;

  fill_state_t state;
  logic [15:0] pattern;
  logic        is_xor;
  logic        last;
  logic        walk_load, walk_step, noop;

  logic [6:0]  x_sum, x_lim;
  logic [9:0]  y_sum, y_lim;
  logic [4:0]  walk_x0, walk_x_end;
  logic [7:0]  walk_y0, walk_y_end;

  // Clip against the right and bottom screen edges; sums are widened so nothing wraps.
  assign x_sum = {2'b00, cmd_x0} + {1'b0, cmd_w};
  assign y_sum = {2'b00, cmd_y0} + {1'b0, cmd_h};
  assign x_lim = (x_sum > 7'(WORDS_PER_ROW)) ? 7'(WORDS_PER_ROW) : x_sum;
  assign y_lim = (y_sum > 10'(ROWS)) ? 10'(ROWS) : y_sum;

  always_comb begin
    walk_x0    = cmd_x0;
    walk_y0    = cmd_y0;
    walk_x_end = 5'(x_lim - 7'd1);
    walk_y_end = 8'(y_lim - 10'd1);
    if (cmd_op == OP_CLEAR) begin
      walk_x0    = '0;
      walk_y0    = '0;
      walk_x_end = 5'(WORDS_PER_ROW - 1);
      walk_y_end = 8'(ROWS - 1);
    end
  end

  assign noop = (cmd_op == OP_NOP) ||
                ((cmd_op != OP_CLEAR) && ((cmd_w == '0) || (cmd_h == '0)));

  assign walk_load = (state == IDLE) && cmd_valid;
  assign walk_step = (state == WR) && !vram_busy && !last;

  rect_walker #(
    .WPR (WORDS_PER_ROW),
    .AW  (ADDR_W)
  ) u_walker (
    .clk   (clk),
    .rst   (rst),
    .x0    (walk_x0),
    .x_end (walk_x_end),
    .y0    (walk_y0),
    .y_end (walk_y_end),
    .load  (walk_load),
    .step  (walk_step),
    .addr  (vram_addr),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      vram_load <= 1'b0;
      vram_din  <= '0;
      pattern   <= '0;
      is_xor    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            is_xor    <= (cmd_op == OP_XOR);
            pattern   <= (cmd_op == OP_CLEAR) ? 16'h0000 : cmd_pattern;
            vram_din  <= (cmd_op == OP_CLEAR) ? 16'h0000 : cmd_pattern;
            if (noop) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cmd_op == OP_XOR) begin
              state <= RD;
            end else begin
              state     <= WR;
              vram_load <= 1'b1;
            end
          end
        end
        WR: begin
          if (!vram_busy) begin
            if (last) begin
              state     <= DONE;
              done      <= 1'b1;
              vram_load <= 1'b0;
            end else if (is_xor) begin
              state     <= RD;
              vram_load <= 1'b0;
            end
          end
        end
        RD: begin
          if (!vram_busy) state <= RDW;
        end
        RDW: begin
          vram_din  <= vram_dout ^ pattern;
          vram_load <= 1'b1;
          state     <= WR;
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign active = ~cmd_ready;

endmodule

// File: tb/tb_vram_fill.sv
// tb/tb_vram_fill.sv - randomized scoreboard bench for vram_fill against a VRAM memory model
module tb_vram_fill;

  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_x0 = '0;
  logic [7:0]  cmd_y0 = '0;
  logic [5:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [15:0] cmd_pattern = '0;
  logic        active, done, vram_load;
  logic [12:0] vram_addr;
  logic [15:0] vram_din;
  logic        vram_busy = 1'b0;
  logic [15:0] vram_dout = '0;

  logic [15:0] mem     [0:8191];
  logic [15:0] ref_mem [0:8191];
  wr_t         exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_mode = 0;
  int acc_cyc = 0;
  int writes_seen = 0;
  int done_seen = 0;
  int done_cycle = 0;

  logic        prev_load = 1'b0, prev_busy = 1'b0;
  logic [12:0] prev_addr = '0;
  logic [15:0] prev_din = '0;

  vram_fill dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x0      (cmd_x0),
    .cmd_y0      (cmd_y0),
    .cmd_w       (cmd_w),
    .cmd_h       (cmd_h),
    .cmd_pattern (cmd_pattern),
    .active      (active),
    .done        (done),
    .vram_load   (vram_load),
    .vram_addr   (vram_addr),
    .vram_din    (vram_din),
    .vram_busy   (vram_busy),
    .vram_dout   (vram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // VRAM port model: writes land and reads return data only when not busy.
  always @(posedge clk) begin
    if (!vram_busy && vram_load) mem[vram_addr] <= vram_din;
    if (!vram_busy && !vram_load) vram_dout <= mem[vram_addr];
    else vram_dout <= 16'($urandom);
  end

  always @(posedge clk) begin
    #1;
    case (busy_mode)
      1: vram_busy = ((cyc - acc_cyc) % 2 == 0);
      2: vram_busy = ($urandom_range(0, 3) == 0);
      default: vram_busy = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted write.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_load = 1'b0;
    end else begin
      n_checks++;
      if (active !== ~cmd_ready) begin
        n_fail++;
        $display("FAIL active_vs_ready cyc=%0d active=%b cmd_ready=%b", cyc, active, cmd_ready);
      end
      if (prev_load && prev_busy) begin
        n_checks++;
        if (vram_load !== 1'b1 || vram_addr !== prev_addr || vram_din !== prev_din) begin
          n_fail++;
          $display("FAIL busy_hold cyc=%0d got load=%b addr=%0d din=%h want load=1 addr=%0d din=%h",
                   cyc, vram_load, vram_addr, vram_din, prev_addr, prev_din);
        end
      end
      if (vram_load && !vram_busy) begin
        writes_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write cyc=%0d addr=%0d din=%h want none", cyc, vram_addr, vram_din);
        end else begin
          e = exp_q.pop_front();
          if (vram_addr !== e.addr || vram_din !== e.data) begin
            n_fail++;
            $display("FAIL write cyc=%0d got addr=%0d din=%h want addr=%0d din=%h",
                     cyc, vram_addr, vram_din, e.addr, e.data);
          end
          ref_mem[e.addr] = e.data;
        end
      end
      if (done) begin
        done_seen++;
        done_cycle = cyc;
      end
      prev_load = vram_load;
      prev_busy = vram_busy;
      prev_addr = vram_addr;
      prev_din  = vram_din;
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference: enumerate the clipped rectangle row by row and push each write.
  function automatic int expect_cmd(input logic [1:0] op, input int x0, input int y0,
                                    input int w, input int h, input logic [15:0] pat);
    int xe, ye, n;
    wr_t e;
    n = 0;
    if (op == 2'b11) return 0;
    if (op == 2'b10) begin
      x0 = 0; y0 = 0; w = 32; h = 256; pat = 16'h0000;
    end
    if (w == 0 || h == 0) return 0;
    xe = ((x0 + w) > 32 ? 32 : (x0 + w)) - 1;
    ye = ((y0 + h) > 256 ? 256 : (y0 + h)) - 1;
    for (int y = y0; y <= ye; y++) begin
      for (int x = x0; x <= xe; x++) begin
        e.addr = 13'(y * 32 + x);
        e.data = (op == 2'b01) ? (ref_mem[y * 32 + x] ^ pat) : pat;
        exp_q.push_back(e);
        n++;
      end
    end
    return n;
  endfunction

  task automatic issue(input logic [1:0] op, input int x0, input int y0,
                       input int w, input int h, input logic [15:0] pat, input int bmode);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("cmd_ready_wait_timeout", 0, 1);
    cmd_op      = op;
    cmd_x0      = 5'(x0);
    cmd_y0      = 8'(y0);
    cmd_w       = 6'(w);
    cmd_h       = 9'(h);
    cmd_pattern = pat;
    cmd_valid   = 1'b1;
    acc_cyc     = cyc + 1;
    busy_mode   = bmode;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input int x0, input int y0,
                         input int w, input int h, input logic [15:0] pat,
                         input int bmode, input int lat);
    int n, w0, d0, t;
    n  = expect_cmd(op, x0, y0, w, h, pat);
    w0 = writes_seen;
    d0 = done_seen;
    issue(op, x0, y0, w, h, pat, bmode);
    t = 0;
    while (done_seen == d0 && t < 40000) begin
      @(posedge clk);
      t++;
    end
    check({name, "_done_seen"}, int'(done_seen != d0), 1);
    if (lat >= 0) check({name, "_latency"}, done_cycle - acc_cyc, lat);
    check({name, "_writes"}, writes_seen - w0, n);
    check({name, "_queue_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_ready_after"}, int'(cmd_ready), 1);
    check({name, "_done_pulses"}, done_seen - d0, 1);
    busy_mode = 0;
  endtask

  initial begin
    int w0, d0, t, n, op, x0, y0, w, h, bm, lat, bad;
    logic [15:0] pat;

    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", int'(cmd_ready), 1);
    check("reset_active", int'(active), 0);
    check("reset_load", int'(vram_load), 0);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(vram_addr), 0);
    check("reset_din", int'(vram_din), 0);
    rst = 1'b0;

    run_cmd("fill_basic", 2'b00, 2, 3, 4, 2, 16'hAAAA, 0, 8);
    run_cmd("fill_busy_alt", 2'b00, 2, 3, 4, 2, 16'hAAAA, 1, 16);

    mem[8191] = 16'h0F0F;
    ref_mem[8191] = 16'h0F0F;
    run_cmd("xor_corner", 2'b01, 31, 255, 4, 4, 16'hFFFF, 0, 3);
    check("xor_corner_value", int'(mem[8191]), 16'hF0F0);

    run_cmd("clear", 2'b10, 7, 9, 3, 5, 16'h1234, 0, 8192);

    run_cmd("noop_w0", 2'b00, 4, 4, 0, 5, 16'h5555, 0, 0);
    run_cmd("noop_h0", 2'b01, 4, 4, 5, 0, 16'h5555, 0, 0);
    run_cmd("noop_op3", 2'b11, 4, 4, 5, 5, 16'h5555, 0, 0);

    for (int k = 0; k < 14; k++) begin
      op  = $urandom_range(0, 9) < 5 ? 0 : ($urandom_range(0, 9) < 8 ? 1 : 3);
      x0  = $urandom_range(0, 31);
      w   = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) begin
        y0 = 240 + $urandom_range(0, 15);
        h  = $urandom_range(0, 511);
      end else begin
        y0 = $urandom_range(0, 255);
        h  = $urandom_range(0, 8);
      end
      pat = 16'($urandom);
      bm  = $urandom_range(0, 2);
      n   = (op == 3 || w == 0 || h == 0) ? 0 :
            (((x0 + w) > 32 ? 32 : x0 + w) - x0) * (((y0 + h) > 256 ? 256 : y0 + h) - y0);
      lat = (bm != 0) ? -1 : ((op == 1) ? 3 * n : n);
      run_cmd("rand", 2'(op), x0, y0, w, h, pat, bm, lat);
    end

    n  = expect_cmd(2'b00, 0, 10, 32, 2, 16'hC3C3);
    w0 = writes_seen;
    d0 = done_seen;
    issue(2'b00, 0, 10, 32, 2, 16'hC3C3, 0);
    t = 0;
    while ((writes_seen - w0) < 5 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("rst_mid_reach5", writes_seen - w0, 5);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_load", int'(vram_load), 0);
    check("rst_mid_ready", int'(cmd_ready), 1);
    check("rst_mid_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    repeat (6) @(posedge clk);
    check("rst_mid_no_done", done_seen - d0, 0);
    check("rst_mid_writes", writes_seen - w0, 5);
    check("rst_mid_mem_row_tail", int'(mem[10 * 32 + 5] == 16'hC3C3 && ref_mem[10 * 32 + 5] != 16'hC3C3), 0);

    run_cmd("after_rst", 2'b01, 3, 10, 6, 3, 16'h0FF0, 0, 54);

    bad = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory_sweep_mismatches", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
